shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Registered multi-step shift engine that sits directly downstream of the 4-bit combinational shifter (hold / shift-left / shift-right / rotate).
- Loads a data word, then applies one shifter operation a programmed number of times, one step per clock.
- Signals completion with a start/busy/done handshake.
- Feeds the register bank and display stages in later labs.

Parameters:
- WIDTH, 4, data word width in bits.
- CNT_W, 3, width of the step-count input; maximum step count is 2^CNT_W - 1.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Load  input  1  when high in IDLE, Q <= DIn.
- DIn  input  WIDTH  parallel load data.
- Start  input  1  when high in IDLE, begins a sequence.
- Op  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 rotate left.
- Count  input  CNT_W  number of steps to apply.
- Q  output  WIDTH  registered data word.
- Busy  output  1  high while steps are being applied.
- Done  output  1  one-cycle pulse after the final step.

Behaviour:
- Reset: when Rst=1 at a rising edge, Q=0, Busy=0, Done=0, state IDLE, latched Op and Count cleared. Rst overrides every other input, including mid-sequence; an aborted sequence never raises Done.
- Step operation, applied to Q each step, MSB = bit WIDTH-1:
  - 00: Q unchanged.
  - 01: Q <= {Q[WIDTH-2:0], 0}.
  - 10: Q <= {0, Q[WIDTH-1:1]}.
  - 11: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- States:
  - IDLE:
    - Busy=0.
    - Load=1 -> Q <= DIn.
    - Start=1 -> latch Op and Count; go to DONE if Count==0, else go to RUN.
    - Load and Start in the same cycle -> the load happens and the sequence starts; steps act on the loaded value.
  - RUN:
    - Busy=1.
    - Each edge applies the latched Op to Q and decrements the remaining count.
    - When the step that brings the remaining count to 0 is applied, go to DONE.
    - Load, Start, Op and Count are ignored, and the latched values are not disturbed.
  - DONE:
    - Done=1, Busy=0, Q holds.
    - Unconditionally returns to IDLE next edge; Load and Start in this cycle are ignored.
- Timing: with Start sampled at edge k, steps occur at edges k+1 .. k+Count. Done is high in the cycle following edge k+Count. Count=0 gives Done one cycle after Start with Q unchanged.
- Latency: Start to Done = Count+1 cycles. Back-to-back sequences need at least one IDLE cycle.
- Op=00 with Count=N is a pure N-cycle delay: Busy for N cycles, Q constant.
- Edge cases:
  - Shift-left or shift-right past WIDTH steps leaves Q=0.
  - Rotate by WIDTH steps returns the original Q.
- Q, Busy and Done are registered outputs with no combinational input-to-output path.

Test Plan:
- Rst=1 for 2 cycles with DIn=1111, Load=1, Start=1 -> Q=0000, Busy=0, Done=0 throughout.
- Load DIn=1011, then Start Op=01 Count=1 -> Q=0110 one cycle after Start, Done pulses exactly once, Busy high for 1 cycle.
- Load 1001, Start Op=10 Count=2 -> Q sequence 1001 -> 0100 -> 0010, Done at Start+3.
- Load 1100 and Start Op=11 Count=3 in the same cycle -> Q sequence 1100 -> 1001 -> 0011 -> 0110, Busy high 3 cycles, then Done.
- Boundary counts:
  - Start Op=01 Count=0 on Q=0101 -> no Busy, Done next cycle, Q=0101.
  - Start Op=00 Count=7 -> Busy for 7 cycles, Q constant, Done at Start+8.
- Abort and ignore:
  - Start Op=01 Count=5 on 1111; assert Start Op=10 Count=1 and Load DIn=0000 during RUN -> both ignored, final Q=0000 after 5 left shifts, Done at Start+6.
  - Repeat, with Rst asserted at step 2 -> Q=0000, IDLE, no Done pulse.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-step shift engine: loads a word, then applies one shift/rotate op Count times, one step per clock.
// Latency: Start to Done = Count+1 cycles; Q/Busy/Done are all registered.
// No backpressure: Load/Start are only honoured in IDLE, and ignored while running or signalling done.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] DIn,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One application of the shifter operation to a data word.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b01:   r = {v[WIDTH-2:0], 1'b0};
      2'b10:   r = {1'b0, v[WIDTH-1:1]};
      2'b11:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // State register: all flops, synchronous reset clears everything including latched op/count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: IDLE waits for Start, RUN counts steps down, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = (Count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and outputs: load/latch in IDLE, step in RUN; Busy/Done are decoded from the next state so they register cleanly.
  always_comb begin
    q_d    = q_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (Load) begin
          q_d = DIn;
        end
        if (Start) begin
          op_d  = Op;
          cnt_d = Count;
        end
      end
      S_RUN: begin
        q_d   = step(q_q, op_q);
        cnt_d = cnt_q - 1'b1;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  assign Q    = q_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
